// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory bank: grants one requester,
// sequences SETUP/STROBE/DONE so strobes only fire on a settled address, and returns a one-cycle ack.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 128,
  parameter int MEM_LAT = 1,
  parameter int FAIR    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  output logic              p0_err_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              p1_err_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic              gnt_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              busy_q;
  logic [1:0]        ack_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata_q [2];

  logic              gnt_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              in_range;

  // On a tie the fair mode hands the bank to whichever port did not get it last time.
  always_comb begin
    gnt_d = 1'b0;
    if (p0_req_i && p1_req_i) begin
      gnt_d = (FAIR != 0) ? ~last_grant_q : 1'b0;
    end else if (p1_req_i) begin
      gnt_d = 1'b1;
    end
    we_d    = gnt_d ? p1_we_i    : p0_we_i;
    addr_d  = gnt_d ? p1_addr_i  : p0_addr_i;
    wdata_d = gnt_d ? p1_wdata_i : p0_wdata_i;
  end

  assign in_range = ({1'b0, addr_q} < DEPTH_X);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p0_req_i || p1_req_i) begin
            state_q <= SETUP;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (in_range) begin
            state_q     <= STROBE;
            cnt_q       <= CNT_LOAD;
            mem_read_q  <= ~we_q;
            mem_write_q <= we_q;
          end else begin
            // Out-of-range accesses complete without ever touching the bank.
            state_q        <= DONE;
            ack_q[gnt_q]   <= 1'b1;
            err_q[gnt_q]   <= 1'b1;
            if (!we_q) begin
              rdata_q[gnt_q] <= '0;
            end
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            state_q        <= DONE;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            ack_q[gnt_q]   <= 1'b1;
            err_q[gnt_q]   <= 1'b0;
            if (!we_q) begin
              rdata_q[gnt_q] <= mem_rdata_i;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          ack_q        <= '0;
          busy_q       <= 1'b0;
          last_grant_q <= gnt_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_ack_o    = ack_q[0];
  assign p1_ack_o    = ack_q[1];
  assign p0_err_o    = err_q[0];
  assign p1_err_o    = err_q[1];
  assign p0_rdata_o  = rdata_q[0];
  assign p1_rdata_o  = rdata_q[1];
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a fair MEM_LAT=1 instance and a fixed-priority MEM_LAT=3 instance,
// each in front of a small behavioural memory bank.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic        p_req   [2][2];
  logic        p_we    [2][2];
  logic [31:0] p_addr  [2][2];
  logic [31:0] p_wdata [2][2];
  logic        p_ack   [2][2];
  logic [31:0] p_rdata [2][2];
  logic        p_err   [2][2];
  logic        mem_read [2];
  logic        mem_write[2];
  logic        busy     [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];
  logic [31:0] mem [2][128];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(128), .MEM_LAT(1), .FAIR(1)) u_fair (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p_req[0][0]), .p0_we_i(p_we[0][0]), .p0_addr_i(p_addr[0][0]), .p0_wdata_i(p_wdata[0][0]),
    .p0_ack_o(p_ack[0][0]), .p0_rdata_o(p_rdata[0][0]), .p0_err_o(p_err[0][0]),
    .p1_req_i(p_req[0][1]), .p1_we_i(p_we[0][1]), .p1_addr_i(p_addr[0][1]), .p1_wdata_i(p_wdata[0][1]),
    .p1_ack_o(p_ack[0][1]), .p1_rdata_o(p_rdata[0][1]), .p1_err_o(p_err[0][1]),
    .mem_read_o(mem_read[0]), .mem_write_o(mem_write[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(128), .MEM_LAT(3), .FAIR(0)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p_req[1][0]), .p0_we_i(p_we[1][0]), .p0_addr_i(p_addr[1][0]), .p0_wdata_i(p_wdata[1][0]),
    .p0_ack_o(p_ack[1][0]), .p0_rdata_o(p_rdata[1][0]), .p0_err_o(p_err[1][0]),
    .p1_req_i(p_req[1][1]), .p1_we_i(p_we[1][1]), .p1_addr_i(p_addr[1][1]), .p1_wdata_i(p_wdata[1][1]),
    .p1_ack_o(p_ack[1][1]), .p1_rdata_o(p_rdata[1][1]), .p1_err_o(p_err[1][1]),
    .mem_read_o(mem_read[1]), .mem_write_o(mem_write[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1])
  );

  // Memory banks: word i resets to A500_00ii, writes land on the edge that ends a write strobe cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[0][i] <= 32'hA500_0000 | i;
    end else if (mem_write[0] && mem_addr[0] < 32'd128) begin
      mem[0][mem_addr[0][6:0]] <= mem_wdata[0];
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[1][i] <= 32'hA500_0000 | i;
    end else if (mem_write[1] && mem_addr[1] < 32'd128) begin
      mem[1][mem_addr[1][6:0]] <= mem_wdata[1];
    end
  end
  assign mem_rdata[0] = (mem_addr[0] < 32'd128) ? mem[0][mem_addr[0][6:0]] : 32'd0;
  assign mem_rdata[1] = (mem_addr[1] < 32'd128) ? mem[1][mem_addr[1][6:0]] : 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Strobe rules: never both strobes, and address/wdata unchanged since the previous cycle whenever a strobe is high.
  logic [31:0] prev_addr[2];
  logic [31:0] prev_wd  [2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        check("strobe_exclusive", {63'd0, mem_read[k] & mem_write[k]}, 64'd0);
        if (mem_read[k] || mem_write[k])
          check("strobe_addr_stable", {mem_addr[k], mem_wdata[k]}, {prev_addr[k], prev_wd[k]});
      end
      prev_addr[k] <= mem_addr[k];
      prev_wd[k]   <= mem_wdata[k];
    end
  end

  typedef struct {
    int          d;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  // Drives one request, counts edges from the sampling edge to the first ack, deasserts after the ack cycle.
  task automatic access(input int d, input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int nrd, output int nwr,
                        output int nbusy_lo, output int nother, output logic [31:0] rdata, output logic err);
    lat = 0; nrd = 0; nwr = 0; nbusy_lo = 0; nother = 0; rdata = '0; err = 1'b0;
    p_we[d][port] = we; p_addr[d][port] = addr; p_wdata[d][port] = wdata; p_req[d][port] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      nrd += int'(mem_read[d]);
      nwr += int'(mem_write[d]);
      if (!busy[d]) nbusy_lo++;
      if (p_ack[d][1-port]) nother++;
      if (p_ack[d][port]) begin
        lat = n; rdata = p_rdata[d][port]; err = p_err[d][port];
        break;
      end
    end
    if (lat == 0) check("ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    p_req[d][port] = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat, nrd, nwr, nbl, noth, L;
    logic [31:0] rd;
    logic er;
    L = (v.d == 0) ? 1 : 3;
    access(v.d, v.port, v.we, v.addr, v.wdata, lat, nrd, nwr, nbl, noth, rd, er);
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_err"}, {63'd0, er}, {63'd0, v.exp_err});
    if (!v.we) check({tag, "_rdata"}, {32'd0, rd}, {32'd0, v.exp_rdata});
    check({tag, "_rd_cycles"}, 64'(nrd), 64'((!v.we && !v.exp_err) ? L : 0));
    check({tag, "_wr_cycles"}, 64'(nwr), 64'((v.we && !v.exp_err) ? L : 0));
    check({tag, "_busy_gap"}, 64'(nbl), 64'd0);
    check({tag, "_other_ack"}, 64'(noth), 64'd0);
    check({tag, "_ack_one_cycle"}, {63'd0, p_ack[v.d][v.port]}, 64'd0);
  endtask

  task automatic rand_port(input int port, input int stop);
    int got;
    logic [31:0] a;
    while (cyc < stop) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      a = 32'($urandom_range(0, 140));
      p_we[0][port] = 1'($urandom_range(0, 1));
      p_addr[0][port] = a;
      p_wdata[0][port] = $urandom;
      p_req[0][port] = 1'b1;
      got = 0;
      for (int n = 0; n < 60; n++) begin
        @(posedge clk); #1;
        if (p_ack[0][port]) begin got = 1; break; end
      end
      check("rand_ack", 64'(got), 64'd1);
      if (got == 1) check("rand_err", {63'd0, p_err[0][port]}, {63'd0, a >= 32'd128});
      @(posedge clk); #1;
      p_req[0][port] = 1'b0;
    end
  endtask

  initial begin
    int order[4];
    int got, both, c0, c1, start;
    vec_t v;

    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        p_req[d][p] = 1'b0; p_we[d][p] = 1'b0; p_addr[d][p] = '0; p_wdata[d][p] = '0;
      end

    vecs[0]  = '{0, 0, 1'b1, 32'd5,   32'hDEAD_BEEF, 32'h0,         1'b0, 3};
    vecs[1]  = '{0, 0, 1'b0, 32'd5,   32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    vecs[2]  = '{0, 1, 1'b0, 32'd127, 32'h0,         32'hA500_007F, 1'b0, 3};
    vecs[3]  = '{0, 1, 1'b0, 32'd128, 32'h0,         32'h0,         1'b1, 2};
    vecs[4]  = '{0, 1, 1'b0, 32'd127, 32'h0,         32'hA500_007F, 1'b0, 3};
    vecs[5]  = '{0, 1, 1'b1, 32'd127, 32'h1234_5678, 32'h0,         1'b0, 3};
    vecs[6]  = '{0, 0, 1'b0, 32'd127, 32'h0,         32'h1234_5678, 1'b0, 3};
    vecs[7]  = '{0, 0, 1'b1, 32'd200, 32'hFFFF_FFFF, 32'h0,         1'b1, 2};
    vecs[8]  = '{0, 1, 1'b0, 32'd72,  32'h0,         32'hA500_0048, 1'b0, 3};
    vecs[9]  = '{1, 0, 1'b0, 32'd10,  32'h0,         32'hA500_000A, 1'b0, 5};
    vecs[10] = '{1, 1, 1'b1, 32'd10,  32'hCAFE_F00D, 32'h0,         1'b0, 5};
    vecs[11] = '{1, 0, 1'b0, 32'd10,  32'h0,         32'hCAFE_F00D, 1'b0, 5};
    vecs[12] = '{1, 1, 1'b0, 32'hFFFF_FFFF, 32'h0,   32'h0,         1'b1, 2};

    #1 rst_n = 1'b0;
    #11;
    for (int d = 0; d < 2; d++) begin
      check("rst_ctrl", {57'd0, mem_read[d], mem_write[d], busy[d], p_ack[d][0], p_ack[d][1],
                         p_err[d][0], p_err[d][1]}, 64'd0);
      check("rst_mem_addr", {32'd0, mem_addr[d]}, 64'd0);
      check("rst_mem_wdata", {32'd0, mem_wdata[d]}, 64'd0);
      check("rst_rdata", {p_rdata[d][0], p_rdata[d][1]}, 64'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Fair mode, both ports held: grants must alternate starting with port 0.
    p_we[0][0] = 1'b0; p_addr[0][0] = 32'd1;
    p_we[0][1] = 1'b1; p_addr[0][1] = 32'd2; p_wdata[0][1] = 32'h22;
    p_req[0][0] = 1'b1; p_req[0][1] = 1'b1;
    got = 0; both = 0;
    for (int n = 0; n < 80 && got < 4; n++) begin
      @(posedge clk); #1;
      if (p_ack[0][0] && p_ack[0][1]) both++;
      if (p_ack[0][0]) begin
        order[got] = 0; got++;
        check("fair_p0_rdata", {32'd0, p_rdata[0][0]}, {32'd0, 32'hA500_0001});
      end else if (p_ack[0][1]) begin
        order[got] = 1; got++;
      end
    end
    p_req[0][0] = 1'b0; p_req[0][1] = 1'b0;
    check("fair_grants", 64'(got), 64'd4);
    check("fair_ack_overlap", 64'(both), 64'd0);
    check("fair_order", {32'd0, 8'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])}, 64'h0000_0000_0001_0001);
    repeat (3) begin @(posedge clk); #1; end
    v = '{0, 0, 1'b0, 32'd2, 32'h0, 32'h22, 1'b0, 3};
    run_vec("fair_wr_readback", v);

    // Fixed priority: port 0 keeps winning until it lets go.
    p_we[1][0] = 1'b0; p_addr[1][0] = 32'd1;
    p_we[1][1] = 1'b1; p_addr[1][1] = 32'd2; p_wdata[1][1] = 32'h33;
    p_req[1][0] = 1'b1; p_req[1][1] = 1'b1;
    c0 = 0; c1 = 0;
    for (int n = 0; n < 120 && c0 < 3; n++) begin
      @(posedge clk); #1;
      if (p_ack[1][0]) c0++;
      if (p_ack[1][1]) c1++;
    end
    p_req[1][0] = 1'b0;
    check("prio_p0_grants", 64'(c0), 64'd3);
    check("prio_p1_starved", 64'(c1), 64'd0);
    got = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (p_ack[1][1]) begin got = 1; break; end
    end
    check("prio_p1_after_release", 64'(got), 64'd1);
    @(posedge clk); #1;
    p_req[1][1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    v = '{1, 0, 1'b0, 32'd2, 32'h0, 32'h33, 1'b0, 5};
    run_vec("prio_wr_readback", v);

    // Reset in the middle of a write strobe.
    p_we[0][0] = 1'b1; p_addr[0][0] = 32'd20; p_wdata[0][0] = 32'h55; p_req[0][0] = 1'b1;
    @(posedge clk); #1;
    check("midrst_setup_no_strobe", {63'd0, mem_write[0]}, 64'd0);
    @(posedge clk); #1;
    check("midrst_strobe_high", {62'd0, mem_write[0], busy[0]}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async_drop", {61'd0, mem_write[0], busy[0], p_ack[0][0]}, 64'd0);
    p_req[0][0] = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_ack", {63'd0, p_ack[0][0]}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = '{0, 0, 1'b1, 32'd20, 32'h77, 32'h0, 1'b0, 3};
    run_vec("postrst_wr", v);
    v = '{0, 0, 1'b0, 32'd20, 32'h0, 32'h77, 1'b0, 3};
    run_vec("postrst_rd", v);

    // Random two-port traffic while the strobe monitor watches.
    start = cyc;
    fork
      rand_port(0, start + 1000);
      rand_port(1, start + 1000);
    join
    repeat (5) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
